// File: rtl/disk_transfer_ctrl.sv
// disk_transfer_ctrl
//   Sequences a block transfer of N words between the disk and main RAM over
//   the RAM transfer port. While a block is moving, ldd locks out other RAM
//   writers. Each word takes two cycles, RD then WR:
//     load  (dir=0): RD presents disk_addr, WR writes disk_q into RAM.
//     store (dir=1): RD reads RAM via q_t into a buffer, WR writes the buffer to disk.
//   Optional feature macro: DISK_CHECKSUM_EN. When it is defined, chk
//   accumulates the sum of the transferred words modulo 2^DATA_WIDTH. When it
//   is undefined, chk is tied to 0.
// Ports
//   clk, rst                  clock (rising edge) and async active-high reset
//   start, dir                command strobe (IDLE only) and direction
//   disk_base, ram_base       first disk / RAM address of the block
//   count                     words to move (0 = no transfer)
//   busy, done                status, done is a 1-cycle pulse
//   ldd, tr, addr_t, data_t   RAM transfer port (q_t is the combinational read data)
//   disk_addr, disk_data      disk port (disk_q is the read data, 1-cycle latency)
//   disk_we
//   chk                       block checksum
module disk_transfer_ctrl #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dir,
  input  logic [DADDR_WIDTH-1:0] disk_base,
  input  logic [ADDR_WIDTH-1:0]  ram_base,
  input  logic [ADDR_WIDTH-1:0]  count,
  output logic                   busy,
  output logic                   done,
  output logic                   ldd,
  output logic                   tr,
  output logic [ADDR_WIDTH-1:0]  addr_t,
  output logic [DATA_WIDTH-1:0]  data_t,
  input  logic [DATA_WIDTH-1:0]  q_t,
  output logic [DADDR_WIDTH-1:0] disk_addr,
  output logic [DATA_WIDTH-1:0]  disk_data,
  output logic                   disk_we,
  input  logic [DATA_WIDTH-1:0]  disk_q,
  output logic [DATA_WIDTH-1:0]  chk
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [DADDR_WIDTH-1:0] dp_q, dp_d;
  logic [ADDR_WIDTH-1:0]  rp_q, rp_d;
  logic [ADDR_WIDTH-1:0]  rem_q, rem_d;
  logic                   dir_q, dir_d;
  logic [DATA_WIDTH-1:0]  wbuf_q, wbuf_d;
`ifdef DISK_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  chk_q, chk_d;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    dp_d    = dp_q;
    rp_d    = rp_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    wbuf_d  = wbuf_q;
`ifdef DISK_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dp_d    = disk_base;
          rp_d    = ram_base;
          rem_d   = count;
          dir_d   = dir;
`ifdef DISK_CHECKSUM_EN
          chk_d   = '0;
`endif
          state_d = (count == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        // Store path: RAM read data is combinational on addr_t, capture it now
        if (dir_q) wbuf_d = q_t;
        state_d = S_WR;
      end
      S_WR: begin
        // Pointers wrap naturally at their widths
        dp_d  = dp_q + DADDR_WIDTH'(1);
        rp_d  = rp_q + ADDR_WIDTH'(1);
        rem_d = rem_q - ADDR_WIDTH'(1);
`ifdef DISK_CHECKSUM_EN
        chk_d = chk_q + (dir_q ? wbuf_q : disk_q);
`endif
        state_d = (rem_q == ADDR_WIDTH'(1)) ? S_DONE : S_RD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dp_q    <= '0;
      rp_q    <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      wbuf_q  <= '0;
`ifdef DISK_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dp_q    <= dp_d;
      rp_q    <= rp_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      wbuf_q  <= wbuf_d;
`ifdef DISK_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  // Output decode from registered state; every output is 0 in IDLE
  logic in_rd, in_wr;
  assign in_rd = (state_q == S_RD);
  assign in_wr = (state_q == S_WR);

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign ldd       = in_rd | in_wr;
  assign tr        = in_wr & ~dir_q;
  assign disk_we   = in_wr & dir_q;
  assign addr_t    = ((in_rd & dir_q) | (in_wr & ~dir_q)) ? rp_q : '0;
  // Load data comes straight from the disk read issued in the preceding RD
  assign data_t    = (in_wr & ~dir_q) ? disk_q : '0;
  assign disk_addr = ((in_rd & ~dir_q) | (in_wr & dir_q)) ? dp_q : '0;
  assign disk_data = (in_wr & dir_q) ? wbuf_q : '0;

`ifdef DISK_CHECKSUM_EN
  assign chk = chk_q;
`else
  assign chk = '0;
`endif

endmodule

// File: tb/tb_disk_transfer_ctrl.sv
// Bench for disk_transfer_ctrl: RAM and disk memory models, directed cases
// plus randomized transfers checked against a word-list reference model.
module tb_disk_transfer_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dir;
  logic [15:0] disk_base;
  logic [15:0] ram_base;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        ldd;
  logic        tr;
  logic [15:0] addr_t;
  logic [15:0] data_t;
  logic [15:0] q_t;
  logic [15:0] disk_addr;
  logic [15:0] disk_data;
  logic        disk_we;
  logic [15:0] disk_q;
  logic [15:0] chk;

  logic [15:0] ram_mem  [0:65535];
  logic [15:0] disk_mem [0:65535];
  logic        pl_en;
  logic        pl_sel;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  int n_total;
  int n_bad;

  disk_transfer_ctrl #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (16),
    .DADDR_WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .disk_base(disk_base),
    .ram_base (ram_base),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .ldd      (ldd),
    .tr       (tr),
    .addr_t   (addr_t),
    .data_t   (data_t),
    .q_t      (q_t),
    .disk_addr(disk_addr),
    .disk_data(disk_data),
    .disk_we  (disk_we),
    .disk_q   (disk_q),
    .chk      (chk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM (combinational read) and disk (synchronous read) models
  assign q_t = ram_mem[addr_t];
  always @(posedge clk) begin
    disk_q <= disk_mem[disk_addr];
    if (disk_we) disk_mem[disk_addr] <= disk_data;
    if (tr) ram_mem[addr_t] <= data_t;
    if (pl_en) begin
      if (pl_sel) disk_mem[pl_addr] <= pl_data;
      else        ram_mem[pl_addr]  <= pl_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Preload one memory word through the model's write port
  task automatic poke(input logic sel, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Run one block and compare against the expected word list.
  // inj > 0 pulses start in that cycle while the block is busy.
  task automatic run_xfer(input logic d, input logic [15:0] db, input logic [15:0] rb,
                          input int n, input int inj);
    logic [15:0] w[$];
    logic [15:0] sum;
    logic [15:0] exp_chk;
    int  k, dcyc, nl, nt, nw;
    bit  both;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      logic [15:0] word;
      word = d ? ram_mem[16'(rb + 16'(i))] : disk_mem[16'(db + 16'(i))];
      w.push_back(word);
      sum = sum + word;
    end
    @(negedge clk);
    start = 1'b1; dir = d; disk_base = db; ram_base = rb; count = 16'(n);
    @(posedge clk);
    k = 0; dcyc = 0; nl = 0; nt = 0; nw = 0; both = 0;
    for (int c = 1; c <= 2 * n + 6 && dcyc == 0; c++) begin
      @(negedge clk);
      start = (c == inj);
      if (ldd) nl++;
      if (tr) nt++;
      if (disk_we) nw++;
      if (tr && disk_we) both = 1;
      if (tr) begin
        if (k < n) begin
          check("ld_addr", 32'(addr_t), 32'(16'(rb + 16'(k))));
          check("ld_data", 32'(data_t), 32'(w[k]));
        end
        k++;
      end
      if (disk_we) begin
        if (k < n) begin
          check("st_addr", 32'(disk_addr), 32'(16'(db + 16'(k))));
          check("st_data", 32'(disk_data), 32'(w[k]));
        end
        k++;
      end
      if (done) dcyc = c;
    end
    start = 1'b0;
    check("done_cycle", 32'(dcyc), 32'(2 * n + 1));
    check("ldd_cycles", 32'(nl), 32'(2 * n));
    check("tr_count", 32'(nt), d ? 32'd0 : 32'(n));
    check("we_count", 32'(nw), d ? 32'(n) : 32'd0);
    check("tr_we_overlap", 32'(both), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (d) check("disk_mem", 32'(disk_mem[16'(db + 16'(i))]), 32'(w[i]));
      else   check("ram_mem",  32'(ram_mem[16'(rb + 16'(i))]),  32'(w[i]));
    end
`ifdef DISK_CHECKSUM_EN
    exp_chk = sum;
`else
    exp_chk = '0;
`endif
    check("chk_at_done", 32'(chk), 32'(exp_chk));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_status", 32'({done, busy, ldd, tr, disk_we}), 32'd0);
    end
    check("chk_hold", 32'(chk), 32'(exp_chk));
  endtask

  initial begin
    logic [15:0] prev;
    n_total = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; dir = 1'b0;
    disk_base = '0; ram_base = '0; count = '0;
    pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({busy, done, ldd, tr, disk_we}), 32'd0);
    check("rst_addr", 32'({addr_t, disk_addr}), 32'd0);
    check("rst_chk", 32'(chk), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'({busy, done, ldd, tr, disk_we}), 32'd0);

    // 1: load four words disk 0x10.. -> RAM 0x100..
    for (int i = 0; i < 4; i++) poke(1'b1, 16'(16'h10 + i), 16'(16'hA0 + i));
    run_xfer(1'b0, 16'h0010, 16'h0100, 4, 0);

    // 2: store three words RAM 0x200.. -> disk 0x40..
    for (int i = 0; i < 3; i++) poke(1'b0, 16'(16'h200 + i), 16'(5 + i));
    run_xfer(1'b1, 16'h0040, 16'h0200, 3, 0);

    // 3: zero-length command
    run_xfer(1'b0, 16'h0000, 16'h0000, 0, 0);

    // 4: RAM pointer wraps past 0xFFFF
    for (int i = 0; i < 4; i++) poke(1'b1, 16'(16'h20 + i), 16'(16'h1230 + i));
    run_xfer(1'b0, 16'h0020, 16'hFFFE, 4, 0);

    // 5a: start pulsed mid-block is ignored
    for (int i = 0; i < 4; i++) poke(1'b1, 16'(16'h30 + i), 16'(16'h7700 + i));
    run_xfer(1'b0, 16'h0030, 16'h0300, 4, 3);

    // 5b: reset after the second WR of a 4-word load
    for (int i = 0; i < 4; i++) poke(1'b1, 16'(16'h50 + i), 16'(16'hBEE0 + i));
    poke(1'b0, 16'h0402, 16'h5A5A);
    prev = ram_mem[16'h0402];
    @(negedge clk);
    start = 1'b1; dir = 1'b0; disk_base = 16'h0050; ram_base = 16'h0400; count = 16'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", 32'({busy, done, ldd, tr, disk_we}), 32'd0);
    check("abort_addr", 32'({addr_t, disk_addr}), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    check("abort_word0", 32'(ram_mem[16'h0400]), 32'hBEE0);
    check("abort_word1", 32'(ram_mem[16'h0401]), 32'hBEE1);
    check("abort_word2", 32'(ram_mem[16'h0402]), 32'(prev));
    rst = 1'b0;
    @(negedge clk);
    run_xfer(1'b0, 16'h0050, 16'h0400, 4, 0);

    // 6: checksum wraps modulo 2^16
    poke(1'b1, 16'h0060, 16'h8000);
    poke(1'b1, 16'h0061, 16'h8000);
    poke(1'b1, 16'h0062, 16'h0003);
    run_xfer(1'b0, 16'h0060, 16'h0500, 3, 0);

    // Randomized transfers
    for (int t = 0; t < 12; t++) begin
      logic        d;
      logic [15:0] db, rb;
      int          n, inj;
      d   = 1'($urandom_range(0, 1));
      db  = 16'($urandom);
      rb  = 16'($urandom);
      n   = int'($urandom_range(0, 10));
      inj = (n > 1) ? int'($urandom_range(0, 2 * n - 1)) : 0;
      for (int i = 0; i < n; i++)
        poke(~d, d ? 16'(rb + 16'(i)) : 16'(db + 16'(i)), 16'($urandom));
      run_xfer(d, db, rb, n, inj);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
